// File: rtl/uart_fifo_tx.sv
// 8N1 UART transmitter fed from a first-word-fall-through FIFO; back-to-back frames with no idle gap.
// Define UART_FIFO_TX_PARITY_EN to insert an even-parity bit between the data bits and the stop bit.
module uart_fifo_tx #(
  parameter int CLOCK_FREQ          = 125_000_000,
  parameter int BAUD_RATE           = 115_200,
  parameter int WIDTH               = 8,
  parameter int SYMBOL_EDGE_TIME    = CLOCK_FREQ / BAUD_RATE,
  parameter int CLOCK_COUNTER_WIDTH = $clog2(SYMBOL_EDGE_TIME)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             tx_en,
  input  logic [WIDTH-1:0] fifo_dout,
  input  logic             fifo_empty,
  output logic             fifo_rd_en,
  output logic             serial_out,
  output logic             busy
);

  localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CLOCK_COUNTER_WIDTH-1:0] TIMER_LAST = CLOCK_COUNTER_WIDTH'(SYMBOL_EDGE_TIME - 1);
  localparam logic [IDX_W-1:0]               IDX_LAST   = IDX_W'(WIDTH - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_FIFO_TX_PARITY_EN
    PARITY,
`endif
    STOP
  } state_t;

  state_t                         state_q, state_d;
  logic [CLOCK_COUNTER_WIDTH-1:0] timer_q, timer_d;
  logic [IDX_W-1:0]               idx_q, idx_d;
  logic [WIDTH-1:0]               shift_q, shift_d;
  logic [WIDTH-1:0]               shift_nxt;
  logic                           serial_out_q, serial_out_d;
  logic                           busy_q, busy_d;
  logic                           bit_done;
  logic                           launch;
`ifdef UART_FIFO_TX_PARITY_EN
  logic                           par_q, par_d;
`endif

  always_comb begin
    bit_done     = (timer_q == TIMER_LAST);
    launch       = tx_en & ~fifo_empty & ((state_q == IDLE) | ((state_q == STOP) & bit_done));
    fifo_rd_en   = launch & rst_n;
    shift_nxt    = shift_q >> 1;

    state_d      = state_q;
    timer_d      = bit_done ? '0 : timer_q + 1'b1;
    idx_d        = idx_q;
    shift_d      = shift_q;
    serial_out_d = serial_out_q;
`ifdef UART_FIFO_TX_PARITY_EN
    par_d        = par_q;
`endif

    case (state_q)
      IDLE: begin
        timer_d      = '0;
        serial_out_d = 1'b1;
      end
      START: begin
        if (bit_done) begin
          state_d      = DATA;
          idx_d        = '0;
          serial_out_d = shift_q[0];
        end
      end
      DATA: begin
        if (bit_done) begin
          shift_d = shift_nxt;
          if (idx_q == IDX_LAST) begin
`ifdef UART_FIFO_TX_PARITY_EN
            state_d      = PARITY;
            serial_out_d = par_q;
`else
            state_d      = STOP;
            serial_out_d = 1'b1;
`endif
          end else begin
            idx_d        = idx_q + 1'b1;
            serial_out_d = shift_nxt[0];
          end
        end
      end
`ifdef UART_FIFO_TX_PARITY_EN
      PARITY: begin
        if (bit_done) begin
          state_d      = STOP;
          serial_out_d = 1'b1;
        end
      end
`endif
      STOP: begin
        if (bit_done) begin
          state_d      = IDLE;
          serial_out_d = 1'b1;
        end
      end
      default: begin
        state_d      = IDLE;
        timer_d      = '0;
        serial_out_d = 1'b1;
      end
    endcase

    // A pop overrides the STOP->IDLE exit so the next start bit follows with no gap.
    if (launch) begin
      state_d      = START;
      timer_d      = '0;
      shift_d      = fifo_dout;
      serial_out_d = 1'b0;
`ifdef UART_FIFO_TX_PARITY_EN
      par_d        = ^fifo_dout;
`endif
    end

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      timer_q      <= '0;
      idx_q        <= '0;
      shift_q      <= '0;
      serial_out_q <= 1'b1;
      busy_q       <= 1'b0;
`ifdef UART_FIFO_TX_PARITY_EN
      par_q        <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      timer_q      <= timer_d;
      idx_q        <= idx_d;
      shift_q      <= shift_d;
      serial_out_q <= serial_out_d;
      busy_q       <= busy_d;
`ifdef UART_FIFO_TX_PARITY_EN
      par_q        <= par_d;
`endif
    end
  end

  assign serial_out = serial_out_q;
  assign busy       = busy_q;

endmodule
